matmul_sequencer: RTL
=====================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL provide: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: RST_N  in  1  reset, synchronous, active-low.
REQ-003 SHALL provide: Start  in  1  run request, level-sampled.
REQ-004 SHALL provide: MemAddr  out  5  operand memory address: A[r][c] at 3r+c (0..8), B[r][c] at 9+3r+c (9..17).
REQ-005 SHALL provide: MemRd  out  1  read strobe; MemData is valid exactly one cycle later.
REQ-006 SHALL provide: MemData  in  8  unsigned operand read data.
REQ-007 SHALL provide: Busy  out  1  high in every state except IDLE and DONE.
REQ-008 SHALL provide: Complete  out  1  run finished, results stable.
REQ-009 SHALL provide: Out1..Out9  out  8 each  registered result C[i][j] on Out(3i+j+1), row-major.

Function
REQ-010 SHALL compute C = A x B for 3x3 unsigned 8-bit matrices using one shared multiply-accumulate unit.
REQ-011 SHALL use states IDLE, RD_A, RD_B, MAC, STORE and DONE.
REQ-012 IDLE -> RD_A when Start = 1; indices i, j and k are cleared and the accumulator is zeroed.
REQ-013 RD_A SHALL drive MemRd = 1 and MemAddr = 3i+k, then go to RD_B.
REQ-014 RD_B SHALL drive MemRd = 1 and MemAddr = 9+3k+j, capture MemData as the A operand, then go to MAC.
REQ-015 MAC SHALL take MemData as the B operand and add A*B to the accumulator.
- If k = 2, go to STORE.
- Otherwise increment k and go to RD_A.
REQ-016 STORE SHALL write the result to Out(3i+j+1), zero the accumulator and k, then advance j, wrapping into i.
- After i = 2, j = 2, go to DONE.
- Otherwise go to RD_A.
REQ-017 Each element SHALL take exactly 10 cycles.
- Complete SHALL rise 91 rising edges after the edge that samples Start = 1 in IDLE.
REQ-018 The accumulator SHALL be 18 bits, which holds the maximum 3*255*255 = 195075 without overflow.
REQ-019 DONE SHALL hold Complete = 1 while Start = 1, and go to IDLE when Start = 0.
- Start held high therefore produces exactly one run.
REQ-020 Start changes while Busy = 1 SHALL be ignored.
REQ-021 MemRd SHALL be 0 outside RD_A and RD_B; MemAddr is don't-care when MemRd = 0.
REQ-022 Out1..Out9 SHALL hold their value until overwritten by a later STORE; they are not cleared at run start.

Reset
REQ-023 When RST_N = 0 at an edge, the block SHALL enter IDLE, including mid-run.
- Reset values: Busy = 0, Complete = 0, MemRd = 0, MemAddr = 0, Out1..Out9 = 0.
- Internal state: accumulator and indices = 0.
REQ-024 The first Start SHALL be sampled on the first edge with RST_N = 1.

Configuration
REQ-025 With MATMUL_SAT_EN defined, a stored result SHALL be min(acc, 255).
REQ-026 Without MATMUL_SAT_EN, a stored result SHALL be acc[7:0] (truncation).

Structure
REQ-027 Package matmul_pkg SHALL hold:
- the state enum;
- N = 3, B_BASE = 9, DATA_W = 8, ACC_W = 18, ADDR_W = 5.
REQ-028 Sub-module mac_unit SHALL hold the 8x8 multiply, the 18-bit accumulator, a clear input and an enable input.
- The FSM, counters and output registers SHALL stay in matmul_sequencer.

Verification
REQ-029 A = identity, B = 1..9 -> Out1..Out9 = 1..9; Complete rises at edge 91.
REQ-030 A and B all 1 -> every Out = 3.
- MemRd address sequence for C[0][0] = 0, 9, 1, 12, 2, 15.
REQ-031 A and B all 255 -> every Out = 3 without MATMUL_SAT_EN, and 255 with MATMUL_SAT_EN.
REQ-032 RST_N = 0 for one edge at cycle 40 of a run -> next cycle: state IDLE, Busy = 0, MemRd = 0, all Out = 0.
- If Start is still high, a fresh run completes 91 edges later.
REQ-033 Start held high for 300 cycles -> exactly one run; Complete stays 1.
- Start = 0 for one cycle then 1 -> Complete drops and a second run completes.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types, sizes and address helpers for the 3x3 matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned N      = 3;
  localparam int unsigned B_BASE = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NOUT   = N * N;
  localparam int unsigned OIDX_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    MAC   = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Address of A[r][c]
  function automatic logic [ADDR_W-1:0] a_addr(input logic [IDX_W-1:0] r,
                                               input logic [IDX_W-1:0] c);
    return ADDR_W'(N) * ADDR_W'(r) + ADDR_W'(c);
  endfunction

  // Address of B[r][c]
  function automatic logic [ADDR_W-1:0] b_addr(input logic [IDX_W-1:0] r,
                                               input logic [IDX_W-1:0] c);
    return ADDR_W'(B_BASE) + ADDR_W'(N) * ADDR_W'(r) + ADDR_W'(c);
  endfunction

  // Row-major result slot of C[r][c]
  function automatic logic [OIDX_W-1:0] out_idx(input logic [IDX_W-1:0] r,
                                                input logic [IDX_W-1:0] c);
    return OIDX_W'(N) * OIDX_W'(r) + OIDX_W'(c);
  endfunction

endpackage

// File: rtl/matmul_sequencer_mac.sv
// Shared 8x8 multiply with 18-bit accumulator; clear has priority over enable.
module mac_unit
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;

  // Unsigned product of the two operands
  assign prod = PROD_W'(a) * PROD_W'(b);

  // Accumulate one product per enabled cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// 3x3 unsigned matrix multiply sequencer: reads A and B from an operand memory
// with one-cycle read latency and computes C = A x B on one shared MAC.
// Optional macro MATMUL_SAT_EN: stored results saturate at 255 instead of
// being truncated to the low 8 bits.
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Start,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [DATA_W-1:0] MemData,
  output logic              Busy,
  output logic              Complete,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2,
  output logic [DATA_W-1:0] Out3,
  output logic [DATA_W-1:0] Out4,
  output logic [DATA_W-1:0] Out5,
  output logic [DATA_W-1:0] Out6,
  output logic [DATA_W-1:0] Out7,
  output logic [DATA_W-1:0] Out8,
  output logic [DATA_W-1:0] Out9
);

  state_t            state;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic [IDX_W-1:0]  k;
  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] res [NOUT];
  logic [ACC_W-1:0]  acc;

  logic              mac_clr_c;
  logic              mac_en_c;
  logic              last_c;
  logic [IDX_W-1:0]  ni_c;
  logic [IDX_W-1:0]  nj_c;

  // Narrow the accumulator to a result byte
  function automatic logic [DATA_W-1:0] store_val(input logic [ACC_W-1:0] v);
`ifdef MATMUL_SAT_EN
    return (v > ACC_W'(255)) ? '1 : DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  mac_unit u_mac (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (a_op),
    .b     (MemData),
    .acc   (acc)
  );

  // MAC control and next output-element indices (j wraps into i)
  always_comb begin
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    last_c    = 1'b0;
    ni_c      = i;
    nj_c      = j + IDX_W'(1);
    if (state == STORE) mac_clr_c = 1'b1;
    if (state == IDLE && Start) mac_clr_c = 1'b1;
    if (state == MAC) mac_en_c = 1'b1;
    if (j == IDX_W'(N - 1)) begin
      nj_c = '0;
      ni_c = i + IDX_W'(1);
    end
    if (i == IDX_W'(N - 1) && j == IDX_W'(N - 1)) last_c = 1'b1;
  end

  // Sequencer FSM; memory strobe/address and Busy are registered from the
  // next state so they line up with the state they belong to
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      a_op     <= '0;
      MemAddr  <= '0;
      MemRd    <= 1'b0;
      Busy     <= 1'b0;
      Complete <= 1'b0;
      for (int unsigned n = 0; n < NOUT; n++) res[n] <= '0;
    end else begin
      MemRd <= 1'b0;
      case (state)
        IDLE: begin
          Complete <= 1'b0;
          Busy     <= 1'b0;
          if (Start) begin
            state   <= RD_A;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            Busy    <= 1'b1;
            MemRd   <= 1'b1;
            MemAddr <= a_addr('0, '0);
          end
        end
        RD_A: begin
          state   <= RD_B;
          MemRd   <= 1'b1;
          MemAddr <= b_addr(k, j);
        end
        RD_B: begin
          a_op  <= MemData;
          state <= MAC;
        end
        MAC: begin
          if (k == IDX_W'(N - 1)) begin
            state <= STORE;
          end else begin
            k       <= k + IDX_W'(1);
            state   <= RD_A;
            MemRd   <= 1'b1;
            MemAddr <= a_addr(i, k + IDX_W'(1));
          end
        end
        STORE: begin
          res[out_idx(i, j)] <= store_val(acc);
          k <= '0;
          i <= ni_c;
          j <= nj_c;
          if (last_c) begin
            state <= DONE;
            Busy  <= 1'b0;
          end else begin
            state   <= RD_A;
            MemRd   <= 1'b1;
            MemAddr <= a_addr(ni_c, '0);
          end
        end
        DONE: begin
          Complete <= 1'b1;
          Busy     <= 1'b0;
          if (!Start) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Out1 = res[0];
  assign Out2 = res[1];
  assign Out3 = res[2];
  assign Out4 = res[3];
  assign Out5 = res[4];
  assign Out6 = res[5];
  assign Out7 = res[6];
  assign Out8 = res[7];
  assign Out9 = res[8];

endmodule
